// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Widths, opcodes and instruction record shared by the ALU issue stage
// Rev    : 1.0
// ============================================================================
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_ADD2 = 3'b101;
    localparam logic [2:0] OP_XOR2 = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } instr_t;

    function automatic logic addr_hit(input logic en,
                                      input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
        return en && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl_if
// Brief  : Instruction, host-write, ALU and writeback signals of the issue stage
// Rev    : 1.0
// ============================================================================
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;
    logic              host_we;
    logic [REG_AW-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              zero_flag;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
               host_we, host_addr, host_data, alu_result, alu_zero, wb_ready,
        input  instr_ready, alu_a, alu_b, alu_ctrl, wb_valid, wb_rd, wb_data,
               zero_flag
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
               host_we, host_addr, host_data, alu_result, alu_zero, wb_ready,
        output instr_ready, alu_a, alu_b, alu_ctrl, wb_valid, wb_rd, wb_data,
               zero_flag
    );

endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module : alu_regfile
// Brief  : 4-entry register file, two async read ports, EX and host write ports
// Rev    : 1.0
// ============================================================================
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            // The retiring instruction outranks a simultaneous host write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem[i] <= '0;
                end else if (ex_we && ex_addr == REG_AW'(i)) begin
                    mem[i] <= ex_data;
                end else if (host_we && host_addr == REG_AW'(i)) begin
                    mem[i] <= host_data;
                end
            end
        end
    endgenerate

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_ctrl
// Brief  : Issue/EX/WB control in front of an 8-bit combinational ALU
// Rev    : 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_ctrl_if.slave bus
);

    instr_t            instr;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [2:0]        ex_op;
    logic              wb_valid_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              zero_q;
    logic              wb_free;
    logic              ex_adv;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign instr = '{op: bus.instr_op, rd: bus.instr_rd,
                     rs1: bus.instr_rs1, rs2: bus.instr_rs2};

    assign wb_free = !wb_valid_q || bus.wb_ready;
    assign ex_adv  = ex_valid && wb_free;
    assign ready   = !ex_valid || ex_adv;
    assign accept  = bus.instr_valid && ready;

    alu_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (instr.rs1),
        .rd_addr_b (instr.rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .ex_we     (ex_adv),
        .ex_addr   (ex_rd),
        .ex_data   (bus.alu_result),
        .host_we   (bus.host_we),
        .host_addr (bus.host_addr),
        .host_data (bus.host_data)
    );

    // Bypass: retiring result first, then same-edge host write, then regfile.
    always_comb begin
        opnd_a = rf_a;
        opnd_b = rf_b;
        if (addr_hit(bus.host_we, bus.host_addr, instr.rs1)) opnd_a = bus.host_data;
        if (addr_hit(bus.host_we, bus.host_addr, instr.rs2)) opnd_b = bus.host_data;
        if (addr_hit(ex_adv, ex_rd, instr.rs1))              opnd_a = bus.alu_result;
        if (addr_hit(ex_adv, ex_rd, instr.rs2))              opnd_b = bus.alu_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_op    <= 3'b000;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_rd    <= instr.rd;
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_op    <= instr.op;
        end else if (ex_adv) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b0;
        end else if (ex_adv) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= ex_rd;
            wb_data_q  <= bus.alu_result;
            zero_q     <= bus.alu_zero;
        end else if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_a       = ex_a;
    assign bus.alu_b       = ex_b;
    assign bus.alu_ctrl    = ex_op;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.zero_flag   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_ctrl
// Brief  : Directed and random self-checking bench with transaction-level model
// Rev    : 1.0
// ============================================================================
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    int   got_q[$];

    alu_issue_ctrl_if bus();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            3'd0, 3'd5: return a + b;
            3'd1:       return a - b;
            3'd2:       return a & b;
            3'd3:       return a | b;
            3'd4, 3'd6: return a ^ b;
            default:    return a >> 1;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 8'h00);

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Architectural model: records in EX/WB slots, regfile written in time order.
    typedef struct {
        logic [1:0] rd;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
    } rec_t;

    logic [7:0] m_rf [4];
    rec_t       ex_q[$];
    rec_t       wb_q[$];
    logic       m_zero;

    always @(posedge clk or negedge rst_n) begin
        bit   wfree, adv, acc;
        rec_t r;
        if (!rst_n) begin
            foreach (m_rf[i]) m_rf[i] = 8'h00;
            ex_q.delete();
            wb_q.delete();
            m_zero = 1'b0;
        end else begin
            wfree = (wb_q.size() == 0) || bus.wb_ready;
            adv   = (ex_q.size() != 0) && wfree;
            acc   = bus.instr_valid && ((ex_q.size() == 0) || adv);
            if (bus.host_we) m_rf[bus.host_addr] = bus.host_data;
            if (wb_q.size() != 0 && bus.wb_ready) void'(wb_q.pop_front());
            if (adv) begin
                r = ex_q.pop_front();
                m_rf[r.rd] = r.res;
                m_zero = r.z;
                wb_q.push_back(r);
            end
            if (acc) begin
                r.rd  = bus.instr_rd;
                r.op  = bus.instr_op;
                r.a   = m_rf[bus.instr_rs1];
                r.b   = m_rf[bus.instr_rs2];
                r.res = alu_fn(r.op, r.a, r.b);
                r.z   = (r.res == 8'h00);
                ex_q.push_back(r);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("instr_ready", bus.instr_ready,
                  int'((ex_q.size() == 0) || (wb_q.size() == 0) || bus.wb_ready));
            check("wb_valid", bus.wb_valid, int'(wb_q.size() != 0));
            check("zero_flag", bus.zero_flag, m_zero);
            if (wb_q.size() != 0) begin
                check("wb_rd", bus.wb_rd, wb_q[0].rd);
                check("wb_data", bus.wb_data, wb_q[0].res);
            end
            if (ex_q.size() != 0) begin
                check("alu_a", bus.alu_a, ex_q[0].a);
                check("alu_b", bus.alu_b, ex_q[0].b);
                check("alu_ctrl", bus.alu_ctrl, ex_q[0].op);
            end
            if (bus.wb_valid && bus.wb_ready) got_q.push_back(int'({bus.wb_rd, bus.wb_data}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        bus.host_we   = 1'b1;
        bus.host_addr = a;
        bus.host_data = d;
        tick();
        bus.host_we   = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2);
        int   n = 0;
        logic r;
        set_instr(op, rd, rs1, rs2);
        do begin
            @(negedge clk);
            r = bus.instr_ready;
            tick();
            n++;
        end while (!r && n < 64);
        bus.instr_valid = 1'b0;
        check("issue_accepted", r, 1);
    endtask

    task automatic issue_chk(input string name, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2,
                             input logic [7:0] exp_d, input logic exp_z);
        issue(op, rd, rs1, rs2);
        tick();
        @(negedge clk);
        check({name, "_wb_valid"}, bus.wb_valid, 1);
        check({name, "_wb_rd"}, bus.wb_rd, rd);
        check({name, "_wb_data"}, bus.wb_data, exp_d);
        check({name, "_zero"}, bus.zero_flag, exp_z);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_instr_ready"}, bus.instr_ready, 1);
        check({name, "_wb_valid"}, bus.wb_valid, 0);
        check({name, "_wb_rd"}, bus.wb_rd, 0);
        check({name, "_wb_data"}, bus.wb_data, 0);
        check({name, "_zero"}, bus.zero_flag, 0);
        check({name, "_alu_a"}, bus.alu_a, 0);
        check({name, "_alu_b"}, bus.alu_b, 0);
        check({name, "_alu_ctrl"}, bus.alu_ctrl, 0);
    endtask

    initial begin
        int exp_bp[3] = '{'h108, 'h20B, 'h303};
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op = 3'd0; bus.instr_rd = 2'd0; bus.instr_rs1 = 2'd0; bus.instr_rs2 = 2'd0;
        bus.host_we = 1'b0; bus.host_addr = 2'd0; bus.host_data = 8'h00;
        bus.wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic add
        host_wr(2'd1, 8'h05);
        host_wr(2'd2, 8'h03);
        set_instr(OP_ADD, 2'd0, 2'd1, 2'd2);
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("basic_alu_a", bus.alu_a, 8'h05);
        check("basic_alu_b", bus.alu_b, 8'h03);
        check("basic_alu_ctrl", bus.alu_ctrl, 0);
        tick();
        @(negedge clk);
        check("basic_wb_valid", bus.wb_valid, 1);
        check("basic_wb_rd", bus.wb_rd, 0);
        check("basic_wb_data", bus.wb_data, 8'h08);
        check("basic_zero", bus.zero_flag, 0);

        // Back-to-back dependent pair
        set_instr(OP_SUB, 2'd3, 2'd1, 2'd1);
        tick();
        set_instr(OP_OR, 2'd0, 2'd3, 2'd2);
        @(negedge clk);
        check("byp_alu_a0", bus.alu_a, 8'h05);
        check("byp_alu_b0", bus.alu_b, 8'h05);
        check("byp_ctrl0", bus.alu_ctrl, 1);
        check("byp_ready", bus.instr_ready, 1);
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        check("byp_wb_data0", bus.wb_data, 8'h00);
        check("byp_zero0", bus.zero_flag, 1);
        check("byp_alu_a1", bus.alu_a, 8'h00);
        check("byp_alu_b1", bus.alu_b, 8'h03);
        check("byp_ctrl1", bus.alu_ctrl, 3);
        tick();
        @(negedge clk);
        check("byp_wb_data1", bus.wb_data, 8'h03);
        check("byp_wb_rd1", bus.wb_rd, 0);
        check("byp_zero1", bus.zero_flag, 0);
        tick();

        // Backpressure: R1=5, R2=3 going in
        got_q.delete();
        bus.wb_ready = 1'b0;
        set_instr(OP_ADD, 2'd1, 2'd1, 2'd2);
        tick();
        set_instr(OP_ADD, 2'd2, 2'd1, 2'd2);
        tick();
        set_instr(OP_XOR, 2'd3, 2'd1, 2'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_ready", bus.instr_ready, 0);
            check("bp_wb_data", bus.wb_data, 8'h08);
            check("bp_wb_rd", bus.wb_rd, 1);
            check("bp_alu_a", bus.alu_a, 8'h08);
            check("bp_alu_b", bus.alu_b, 8'h03);
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        check("bp_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("bp_order", (got_q.size() > i) ? got_q[i] : -1, exp_bp[i]);

        // Same-edge writes: same address, then different addresses
        host_wr(2'd1, 8'h10);
        host_wr(2'd2, 8'h01);
        set_instr(OP_ADD, 2'd3, 2'd1, 2'd2);
        tick();
        bus.instr_valid = 1'b0;
        host_wr(2'd3, 8'hAA);
        issue_chk("coll_same", OP_OR, 2'd0, 2'd3, 2'd3, 8'h11, 1'b0);
        set_instr(OP_ADD, 2'd3, 2'd1, 2'd2);
        tick();
        bus.instr_valid = 1'b0;
        host_wr(2'd2, 8'h55);
        issue_chk("coll_diff", OP_ADD, 2'd0, 2'd3, 2'd2, 8'h66, 1'b0);

        // Wraparound and shift
        host_wr(2'd1, 8'hFF);
        host_wr(2'd2, 8'h01);
        issue_chk("wrap", OP_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 1'b1);
        issue_chk("shr", OP_SHR, 2'd0, 2'd1, 2'd2, 8'h7F, 1'b0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr_op    = 3'($urandom_range(0, 7));
            bus.instr_rd    = 2'($urandom_range(0, 3));
            bus.instr_rs1   = 2'($urandom_range(0, 3));
            bus.instr_rs2   = 2'($urandom_range(0, 3));
            bus.host_we     = ($urandom_range(0, 3) == 0);
            bus.host_addr   = 2'($urandom_range(0, 3));
            bus.host_data   = 8'($urandom_range(0, 255));
            bus.wb_ready    = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Asynchronous reset in the middle of traffic
        bus.instr_valid = 1'b0;
        bus.host_we     = 1'b0;
        bus.wb_ready    = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue_chk("rst_r0", OP_ADD, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1);
        issue_chk("rst_r3r1", OP_OR, 2'd0, 2'd3, 2'd1, 8'h00, 1'b1);
        issue_chk("rst_r2r3", OP_ADD, 2'd1, 2'd2, 2'd3, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
`default_nettype wire
